instruction_decode_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational instruction decoder. Accepts instruction/opcode pairs over a valid/ready handshake into a DEPTH-entry instruction buffer (FIFO). Decodes the buffer head into a registered control bundle with its own valid/ready handshake toward execute. Adds back-pressure, a synchronous flush for branch/jump redirect, an illegal-opcode flag and an occupancy count. Sits between fetch and execute.

---
 rtl/instruction_decode_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_instruction_decode_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode_pipe.sv
// -----------------------------------------------------------------------------
// instruction_decode_pipe
//
// Purpose:
//   Pipelined instruction decoder sitting between fetch and execute. Fetched
//   instruction/opcode pairs are queued in a DEPTH-entry buffer. The buffer
//   head is decoded into a registered control bundle that is handed to
//   execute over its own handshake. A synchronous flush discards all queued
//   and decoded work, for example on a branch/jump redirect.
//
// Handshakes (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The producer holds its payload stable while valid && !ready. ready may
//   depend only on registered state (plus flush on the input side) and never
//   on the partner's valid in the same cycle.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   flush           synchronous flush, highest priority after reset
//   in_valid/in_ready/in_instr/in_opcode
//                   fetch side; in_ready = !full && !flush
//   out_valid/out_ready
//                   execute side handshake for the decoded bundle
//   out_instr, out_alu_op, out_data_src, out_reg_write, out_branch_op,
//   out_jump_op, out_illegal
//                   decoded bundle, held stable while stalled
//   count           buffer occupancy 0..DEPTH (excludes the decode register)
// -----------------------------------------------------------------------------
module instruction_decode_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [4:0]       in_opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic [4:0]       out_alu_op,
    output logic [1:0]       out_data_src,
    output logic [1:0]       out_reg_write,
    output logic [4:0]       out_branch_op,
    output logic [4:0]       out_jump_op,
    output logic             out_illegal,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [4:0] OP_RTYPE  = 5'b00000;
    localparam logic [4:0] OP_ITYPE  = 5'b00100;
    localparam logic [4:0] OP_BRANCH = 5'b01000;
    localparam logic [4:0] OP_JUMP   = 5'b01001;

    // Buffer storage. Contents need no reset: an entry is only read after
    // it has been written, tracked by count_q.
    logic [XLEN-1:0]  instr_mem  [DEPTH];
    logic [4:0]       opcode_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic             full_q;

    logic             push;
    logic             load;
    logic             fifo_empty;

    logic [XLEN-1:0]  head_instr;
    logic [4:0]       head_opcode;

    logic [4:0]       dec_alu_op;
    logic [1:0]       dec_data_src;
    logic [1:0]       dec_reg_write;
    logic [4:0]       dec_branch_op;
    logic [4:0]       dec_jump_op;
    logic             dec_illegal;

    // Registered full flag keeps in_ready free of any combinational path
    // from out_ready; a pop in the same cycle does not open a slot early.
    assign in_ready   = !full_q && !flush;
    assign push       = in_valid && in_ready;
    assign fifo_empty = (count_q == '0);
    assign load       = !flush && !fifo_empty && (!out_valid || out_ready);
    assign count      = count_q;

    always_comb begin
        count_next = count_q;
        case ({push, load})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
        endcase
    end

    // DEPTH is a power of two, so pointer increment wraps by overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_next;
            full_q  <= (count_next == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr]  <= in_instr;
            opcode_mem[wr_ptr] <= in_opcode;
        end
    end

    assign head_instr  = instr_mem[rd_ptr];
    assign head_opcode = opcode_mem[rd_ptr];

    // Decode of the buffer head; unknown opcodes produce an all-zero
    // control set and raise the illegal flag.
    always_comb begin
        dec_alu_op    = 5'b00000;
        dec_data_src  = 2'b00;
        dec_reg_write = 2'b00;
        dec_branch_op = 5'b00000;
        dec_jump_op   = 5'b00000;
        dec_illegal   = 1'b0;
        case (head_opcode)
            OP_RTYPE: begin
                dec_alu_op    = head_instr[4:0];
                dec_data_src  = 2'b11;
                dec_reg_write = 2'b10;
            end
            OP_ITYPE: begin
                dec_data_src  = 2'b10;
                dec_reg_write = 2'b10;
            end
            OP_BRANCH: begin
                dec_alu_op    = 5'b01000;
                dec_data_src  = 2'b01;
                dec_branch_op = 5'b00001;
            end
            OP_JUMP: begin
                dec_jump_op   = 5'b00001;
            end
            default: begin
                dec_illegal   = 1'b1;
            end
        endcase
    end

    // Decode register: loads whenever it is empty or being consumed and the
    // buffer has something; drops valid when consumed with nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_instr     <= '0;
            out_alu_op    <= '0;
            out_data_src  <= '0;
            out_reg_write <= '0;
            out_branch_op <= '0;
            out_jump_op   <= '0;
            out_illegal   <= 1'b0;
        end else if (flush) begin
            out_valid     <= 1'b0;
            out_instr     <= '0;
            out_alu_op    <= '0;
            out_data_src  <= '0;
            out_reg_write <= '0;
            out_branch_op <= '0;
            out_jump_op   <= '0;
            out_illegal   <= 1'b0;
        end else if (load) begin
            out_valid     <= 1'b1;
            out_instr     <= head_instr;
            out_alu_op    <= dec_alu_op;
            out_data_src  <= dec_data_src;
            out_reg_write <= dec_reg_write;
            out_branch_op <= dec_branch_op;
            out_jump_op   <= dec_jump_op;
            out_illegal   <= dec_illegal;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_decode_pipe.sv
// -----------------------------------------------------------------------------
// tb_instruction_decode_pipe
//
// Scoreboard bench for instruction_decode_pipe. Every instruction accepted on
// the fetch side is queued as {instr, opcode}; the output monitor pops the
// queue on each execute-side transfer and compares the DUT bundle with the
// decode table applied to the popped entry. Flush and reset empty the queue.
// -----------------------------------------------------------------------------
module tb_instruction_decode_pipe;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BW    = XLEN + 20;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_instr;
    logic [4:0]       in_opcode;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_instr;
    logic [4:0]       out_alu_op;
    logic [1:0]       out_data_src;
    logic [1:0]       out_reg_write;
    logic [4:0]       out_branch_op;
    logic [4:0]       out_jump_op;
    logic             out_illegal;
    logic [CNT_W-1:0] count;

    logic [XLEN+4:0]  exp_q[$];
    int               hs_cyc[$];
    int               n_total;
    int               n_bad;
    int               cyc;

    instruction_decode_pipe #(
        .XLEN (XLEN),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_opcode    (in_opcode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_alu_op   (out_alu_op),
        .out_data_src (out_data_src),
        .out_reg_write(out_reg_write),
        .out_branch_op(out_branch_op),
        .out_jump_op  (out_jump_op),
        .out_illegal  (out_illegal),
        .count        (count)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Control set {alu_op, data_src, reg_write, branch_op, jump_op, illegal}
    // straight from the decode table.
    function automatic logic [19:0] ref_ctrl(input logic [4:0] op, input logic [XLEN-1:0] instr);
        if (op == 5'b00000)      return {instr[4:0], 2'b11, 2'b10, 5'b00000, 5'b00000, 1'b0};
        else if (op == 5'b00100) return {5'b00000,   2'b10, 2'b10, 5'b00000, 5'b00000, 1'b0};
        else if (op == 5'b01000) return {5'b01000,   2'b01, 2'b00, 5'b00001, 5'b00000, 1'b0};
        else if (op == 5'b01001) return {5'b00000,   2'b00, 2'b00, 5'b00000, 5'b00001, 1'b0};
        else                     return {5'b00000,   2'b00, 2'b00, 5'b00000, 5'b00000, 1'b1};
    endfunction

    function automatic logic [BW-1:0] dut_bundle();
        return {out_instr, out_alu_op, out_data_src, out_reg_write,
                out_branch_op, out_jump_op, out_illegal};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- input recorder ----------------
    // Records accepted pushes and checks that in_ready reflects fullness.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !flush) begin
                check("in_ready_vs_count", 64'(in_ready), 64'(count != CNT_W'(DEPTH)));
                if (in_valid && in_ready) exp_q.push_back({in_instr, in_opcode});
            end
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        logic             stalled;
        logic [BW-1:0]    held;
        logic [XLEN+4:0]  ent;
        stalled = 1'b0;
        held    = '0;
        cyc     = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                stalled = 1'b0;
                continue;
            end
            if (flush) begin
                exp_q.delete();
                stalled = 1'b0;
                continue;
            end
            if (stalled && out_valid) check("hold_stable", 64'(dut_bundle()), 64'(held));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    ent = exp_q.pop_front();
                    check("bundle", 64'(dut_bundle()),
                          64'({ent[XLEN+4:5], ref_ctrl(ent[4:0], ent[XLEN+4:5])}));
                    hs_cyc.push_back(cyc);
                end
            end
            stalled = out_valid && !out_ready;
            held    = dut_bundle();
        end
    end

    // Buffered work in the DUT equals buffer occupancy plus the decode register.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                check("count_le_depth", 64'(count <= CNT_W'(DEPTH)), 64'd1);
                check("inflight", 64'(exp_q.size()), 64'(int'(count) + int'(out_valid)));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_one(input logic [XLEN-1:0] instr, input logic [4:0] op);
        int waited;
        waited    = 0;
        in_valid  = 1'b1;
        in_instr  = instr;
        in_opcode = op;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        check("push_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain", 64'(exp_q.size() == 0 && !out_valid), 64'd1);
    endtask

    task automatic fill_full();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push_one(32'h1000_0000 + 32'(i), 5'b00100);
    endtask

    // ---------------- main sequence ----------------
    logic [4:0] legal_ops [4] = '{5'b00000, 5'b00100, 5'b01000, 5'b01001};

    initial begin
        int base;
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_opcode = '0;
        out_ready = 1'b0;

        // Reset state
        #22;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_bundle", 64'(dut_bundle()), 64'd0);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R-type with 2-edge latency
        out_ready = 1'b1;
        push_one(32'h00431020, 5'b00000);
        @(posedge clk);
        #1;
        check("rtype_valid", 64'(out_valid), 64'd1);
        check("rtype_bundle", 64'(dut_bundle()),
              64'({32'h00431020, 5'b00000, 2'b11, 2'b10, 5'b00000, 5'b00000, 1'b0}));
        wait_drain();

        // Back-to-back stream: three consecutive outputs
        base = hs_cyc.size();
        push_one(32'h20310234, 5'b00100);
        push_one(32'h10a0fffb, 5'b01000);
        push_one(32'h08000010, 5'b01001);
        wait_drain();
        check("stream_count", 64'(hs_cyc.size() - base), 64'd3);
        if (hs_cyc.size() - base == 3)
            check("stream_consecutive", 64'(hs_cyc[base + 2] - hs_cyc[base]), 64'd2);

        // Back-pressure: fill, then try one more
        fill_full();
        in_valid  = 1'b1;
        in_instr  = 32'hdead_beef;
        in_opcode = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", 64'(in_ready), 64'd0);
            check("full_count", 64'(count), 64'(DEPTH));
            check("full_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Flush with count = 2, out_valid = 1 and a push attempt
        out_ready = 1'b0;
        push_one(32'h2000_0001, 5'b00100);
        push_one(32'h2000_0002, 5'b01000);
        push_one(32'h2000_0003, 5'b01001);
        check("pre_flush_count", 64'(count), 64'd2);
        check("pre_flush_valid", 64'(out_valid), 64'd1);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h3000_0000;
        in_opcode = 5'b00000;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("post_flush_count", 64'(count), 64'd0);
        check("post_flush_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("post_flush_not_taken", 64'(count), 64'd0);
        out_ready = 1'b1;

        // Illegal opcode
        push_one(32'hffff_ffff, 5'b11111);
        @(posedge clk);
        #1;
        check("illegal_valid", 64'(out_valid), 64'd1);
        check("illegal_bundle", 64'({out_alu_op, out_data_src, out_reg_write,
                                     out_branch_op, out_jump_op, out_illegal}),
              64'({5'b0, 2'b0, 2'b0, 5'b0, 5'b0, 1'b1}));
        wait_drain();

        // Random traffic with random back-pressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel       = $urandom_range(0, 4);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = $urandom();
            in_opcode = (sel < 4) ? legal_ops[sel] : 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Asynchronous reset while full
        fill_full();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        push_one(32'h00431020, 5'b00000);
        @(posedge clk);
        #1;
        check("after_rst_valid", 64'(out_valid), 64'd1);
        check("after_rst_bundle", 64'(dut_bundle()),
              64'({32'h00431020, 5'b00000, 2'b11, 2'b10, 5'b00000, 5'b00000, 1'b0}));
        wait_drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
